// File: rtl/rv32ima_pkg.sv
// Shared core types: ALU op encoding, machine word, register index width and
// the scheduler state encoding used by alu_rf_sched.
package rv32ima_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WRITE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter. The search starts one past the last winner;
// the pointer only moves when the caller signals that the grant was taken.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             update,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr_q;
    int               cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr_q) + k) % N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        grant[grant_idx] = any;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IDX_W'(N - 1);
        end else if (update) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/alu_rf_sched.sv
// Shares one regfile (2R/1W) and one ALU between NREQ requesters. Each granted
// request runs READ -> EXEC -> WRITE, for a fixed four-cycle occupancy.
module alu_rf_sched
    import rv32ima_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NREQ-1:0]                      req_valid,
    output logic [NREQ-1:0]                      req_ready,
    input  logic [NREQ-1:0][REG_IDX_W-1:0]       req_rs1,
    input  logic [NREQ-1:0][REG_IDX_W-1:0]       req_rs2,
    input  logic [NREQ-1:0][REG_IDX_W-1:0]       req_rd,
    input  aluop_t [NREQ-1:0]                    req_op,
    output logic [NREQ-1:0]                      rsp_valid,
    output word_t                                rsp_data,
    output logic [REG_IDX_W-1:0]                 rf_rsel1,
    output logic [REG_IDX_W-1:0]                 rf_rsel2,
    input  word_t                                rf_rdat1,
    input  word_t                                rf_rdat2,
    output logic [REG_IDX_W-1:0]                 rf_wsel,
    output logic                                 rf_wen,
    output word_t                                rf_wdat,
    output word_t                                alu_in1,
    output word_t                                alu_in2,
    output aluop_t                               alu_op,
    input  word_t                                alu_out,
    output logic                                 busy,
    output logic [CNT_W-1:0]                     op_count
);

    localparam int IDX_W = $clog2(NREQ);

    sched_state_t           state_q, state_d;
    logic [NREQ-1:0]        gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_any;
    logic                   hs;

    logic [REG_IDX_W-1:0]   rs1_q, rs2_q, rd_q;
    aluop_t                 op_q;
    logic [IDX_W-1:0]       idx_q;
    word_t                  opa_q, opb_q, res_q;
    logic [CNT_W-1:0]       cnt_q;

    assign hs = (state_q == IDLE) && gnt_any;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .update    (hs),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .any       (gnt_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WRITE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            op_q  <= ALU_ADD;
            idx_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (hs) begin
                    rs1_q <= req_rs1[gnt_idx];
                    rs2_q <= req_rs2[gnt_idx];
                    rd_q  <= req_rd[gnt_idx];
                    op_q  <= req_op[gnt_idx];
                    idx_q <= gnt_idx;
                end
                READ: begin
                    opa_q <= rf_rdat1;
                    opb_q <= rf_rdat2;
                end
                EXEC:    res_q <= alu_out;
                default: cnt_q <= cnt_q + CNT_W'(1);
            endcase
        end
    end

    // Ready is held low while rst is asserted so no handshake is offered in reset.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rf_rsel1  = '0;
        rf_rsel2  = '0;
        rf_wsel   = '0;
        rf_wen    = 1'b0;
        rf_wdat   = '0;
        alu_in1   = '0;
        alu_in2   = '0;
        alu_op    = ALU_ADD;
        case (state_q)
            IDLE: if (!rst) req_ready = gnt;
            READ: begin
                rf_rsel1 = rs1_q;
                rf_rsel2 = rs2_q;
            end
            EXEC: begin
                alu_in1 = opa_q;
                alu_in2 = opb_q;
                alu_op  = op_q;
            end
            default: begin
                rf_wsel          = rd_q;
                rf_wdat          = res_q;
                rf_wen           = (rd_q != '0);
                rsp_valid[idx_q] = 1'b1;
            end
        endcase
    end

    assign rsp_data = res_q;
    assign busy     = (state_q != IDLE);
    assign op_count = cnt_q;

endmodule
